backtrack_unit: RTL and testbench

Conflict-driven backtrack controller for the DPLL solver core. On a conflict it flushes the imply stack, pops the trace table until the most recent decision, unassigns every popped variable, then flips that decision and re-pushes it as a forced assignment. If the trace empties with no decision found, it reports UNSAT. It is the reader/unwinder of the trace table that the decide and propagate logic fills.

---
 rtl/sat_pkg.sv | 27 ++
 rtl/backtrack_unit.sv | 136 +++++++++++++
 tb/tb_backtrack_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared definitions for the DPLL solver core.
//   - default variable index width and trace depth
//   - trace entry type encodings and entry struct
//   - backtrack controller state encoding
package sat_pkg;

    localparam int VARIABLE_INDEXES = 8;
    localparam int NUM_VARIABLE     = 128;

    localparam logic TYPE_DECIDE = 1'b0;
    localparam logic TYPE_FORCED = 1'b1;

    typedef struct packed {
        logic                        entry_type;
        logic                        val;
        logic [VARIABLE_INDEXES-1:0] var_idx;
    } trace_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        POP,
        FLIP,
        FINISH
    } backtrack_state_e;

endpackage

// File: rtl/backtrack_unit.sv
// Conflict-driven backtrack controller.
// On start: flush the imply stack, pop the trace table down to and including
// the newest decision (unassigning every popped variable), then push the
// flipped decision back as a forced entry and assign it. If the trace runs
// empty first, finish with unsat.
// Ports:
//   clock, reset (async, active low)
//   start                         - begin backtrack, honoured only when idle
//   busy                          - not idle
//   imply_flush                   - one-cycle imply stack clear
//   trace_pop / trace_type/val/var/empty - trace table read side
//   trace_push / push_type/val/var       - trace table write side
//   unassign_valid / unassign_var - clear a variable assignment
//   assign_valid / assign_var/val - write the flipped assignment
//   done / unsat                  - completion pulse and its result
//   pop_count                     - entries popped by the last backtrack
module backtrack_unit
    import sat_pkg::*;
#(
    parameter int VARIABLE_INDEXES = sat_pkg::VARIABLE_INDEXES,
    parameter int NUM_VARIABLE     = sat_pkg::NUM_VARIABLE,
    localparam int PCW             = $clog2(NUM_VARIABLE) + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        imply_flush,
    output logic                        trace_pop,
    input  logic                        trace_type,
    input  logic                        trace_val,
    input  logic [VARIABLE_INDEXES-1:0] trace_var,
    input  logic                        trace_empty,
    output logic                        trace_push,
    output logic                        push_type,
    output logic                        push_val,
    output logic [VARIABLE_INDEXES-1:0] push_var,
    output logic                        unassign_valid,
    output logic [VARIABLE_INDEXES-1:0] unassign_var,
    output logic                        assign_valid,
    output logic [VARIABLE_INDEXES-1:0] assign_var,
    output logic                        assign_val,
    output logic                        done,
    output logic                        unsat,
    output logic [PCW-1:0]              pop_count
);

    backtrack_state_e            state, state_nxt;
    logic [VARIABLE_INDEXES-1:0] flip_var;
    logic                        flip_val;
    logic                        unsat_q;
    logic                        popping;

    assign popping = (state == POP) && !trace_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            flip_var  <= '0;
            flip_val  <= 1'b0;
            unsat_q   <= 1'b0;
            pop_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start)
                pop_count <= '0;
            if (popping) begin
                if (pop_count != '1)
                    pop_count <= pop_count + PCW'(1);
                // newest decision: remember it inverted for the FLIP push
                if (trace_type == TYPE_DECIDE) begin
                    flip_var <= trace_var;
                    flip_val <= ~trace_val;
                end
            end
            if (state == POP && trace_empty)
                unsat_q <= 1'b1;
            if (state == FLIP)
                unsat_q <= 1'b0;
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = (state != IDLE);
        imply_flush    = 1'b0;
        trace_pop      = 1'b0;
        trace_push     = 1'b0;
        push_type      = 1'b0;
        push_val       = 1'b0;
        push_var       = '0;
        unassign_valid = 1'b0;
        unassign_var   = '0;
        assign_valid   = 1'b0;
        assign_var     = '0;
        assign_val     = 1'b0;
        done           = 1'b0;
        unsat          = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = FLUSH;
            FLUSH: begin
                imply_flush = 1'b1;
                state_nxt   = POP;
            end
            POP: begin
                if (trace_empty) begin
                    state_nxt = FINISH;
                end else begin
                    trace_pop      = 1'b1;
                    unassign_valid = 1'b1;
                    unassign_var   = trace_var;
                    if (trace_type == TYPE_DECIDE)
                        state_nxt = FLIP;
                end
            end
            FLIP: begin
                // at least one entry was just popped, so the trace has room
                trace_push   = 1'b1;
                push_type    = TYPE_FORCED;
                push_val     = flip_val;
                push_var     = flip_var;
                assign_valid = 1'b1;
                assign_var   = flip_var;
                assign_val   = flip_val;
                state_nxt    = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                unsat     = unsat_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_backtrack_unit.sv
// Self-checking bench for backtrack_unit: a behavioural trace stack feeds the
// DUT; directed vectors give the expected latency, result and push.
module tb_backtrack_unit;
    import sat_pkg::*;

    localparam int VW  = 8;
    localparam int PCW = $clog2(128) + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, imply_flush, trace_pop, trace_type, trace_val, trace_empty;
    logic [VW-1:0] trace_var, push_var, unassign_var, assign_var;
    logic trace_push, push_type, push_val, unassign_valid, assign_valid, assign_val;
    logic done, unsat;
    logic [PCW-1:0] pop_count;

    always #5 clock = ~clock;

    backtrack_unit #(.VARIABLE_INDEXES(VW), .NUM_VARIABLE(128)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy),
        .imply_flush(imply_flush), .trace_pop(trace_pop), .trace_type(trace_type),
        .trace_val(trace_val), .trace_var(trace_var), .trace_empty(trace_empty),
        .trace_push(trace_push), .push_type(push_type), .push_val(push_val),
        .push_var(push_var), .unassign_valid(unassign_valid), .unassign_var(unassign_var),
        .assign_valid(assign_valid), .assign_var(assign_var), .assign_val(assign_val),
        .done(done), .unsat(unsat), .pop_count(pop_count)
    );

    // trace stack model: entry = {type, val, var}, top at sp-1
    logic [9:0] mem [0:255];
    logic [9:0] ld_mem [0:255];
    int sp = 0;
    int ld_n = 0;
    logic ld_req = 1'b0;

    assign trace_empty = (sp == 0);
    assign trace_type  = (sp > 0) ? mem[sp-1][9]   : 1'b0;
    assign trace_val   = (sp > 0) ? mem[sp-1][8]   : 1'b0;
    assign trace_var   = (sp > 0) ? mem[sp-1][7:0] : '0;

    always @(posedge clock) begin
        if (ld_req) begin
            mem <= ld_mem;
            sp  <= ld_n;
        end else if (trace_pop && sp > 0) begin
            sp <= sp - 1;
        end else if (trace_push) begin
            mem[sp] <= {push_type, push_val, push_var};
            sp      <= sp + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int n);
        ld_n   = n;
        ld_req = 1'b1;
        @(posedge clock);
        #1 ld_req = 1'b0;
    endtask

    // Run one backtrack on the current stack; poke_k re-asserts start in
    // that cycle to confirm it is ignored while busy.
    task automatic execute(input int done_k, input logic exp_unsat, input int pcnt,
                           input logic push_en, input logic [7:0] pvar, input logic pval,
                           input int poke_k);
        int exp_un [0:255];
        int n_un, ui, sp0;
        n_un = 0;
        ui   = 0;
        sp0  = sp;
        for (int i = sp - 1; i >= 0; i--) begin
            exp_un[n_un] = int'(mem[i][7:0]);
            n_un++;
            if (mem[i][9] == TYPE_DECIDE) break;
        end
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clock);
            start = (k == poke_k);
            if (k == 1) check("imply_flush", imply_flush, 1);
            else        check("no_flush", imply_flush, 0);
            check("pop_push_excl", trace_pop & trace_push, 0);
            if (unassign_valid) begin
                if (ui < n_un) check("unassign_var", unassign_var, exp_un[ui]);
                else           check("extra_unassign", 1, 0);
                ui++;
            end else begin
                check("unassign_var_zero", unassign_var, 0);
            end
            check("trace_push", trace_push, push_en && (k == done_k - 1));
            if (trace_push) begin
                check("push_type", push_type, 1);
                check("push_var", push_var, pvar);
                check("push_val", push_val, pval);
                check("assign_valid", assign_valid, 1);
                check("assign_var", assign_var, pvar);
                check("assign_val", assign_val, pval);
            end else begin
                check("assign_idle", {assign_valid, assign_val, assign_var, push_var}, 0);
            end
            check("done", done, k == done_k);
            if (done) check("unsat", unsat, exp_unsat);
            else      check("unsat_low", unsat, 0);
            check("busy", busy, k <= done_k);
        end
        start = 1'b0;
        check("unassign_count", ui, exp_unsat ? sp0 : n_un);
        check("pop_count", pop_count, pcnt);
        check("stack_depth", sp, sp0 - pcnt + (push_en ? 1 : 0));
    endtask

    typedef struct {
        int         n;
        logic [9:0] ent [0:3];
        int         done_k;
        logic       unsat;
        int         pcnt;
        logic       push_en;
        logic [7:0] pvar;
        logic       pval;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        vecs[0] = '{3, '{{1'b0,1'b1,8'd3}, {1'b1,1'b0,8'd5}, {1'b1,1'b1,8'd7}, 10'd0}, 6, 1'b0, 3, 1'b1, 8'd3, 1'b0};
        vecs[1] = '{1, '{{1'b0,1'b0,8'd1}, 10'd0, 10'd0, 10'd0}, 4, 1'b0, 1, 1'b1, 8'd1, 1'b1};
        vecs[2] = '{2, '{{1'b1,1'b1,8'd2}, {1'b1,1'b0,8'd4}, 10'd0, 10'd0}, 5, 1'b1, 2, 1'b0, 8'd0, 1'b0};
        vecs[3] = '{0, '{10'd0, 10'd0, 10'd0, 10'd0}, 3, 1'b1, 0, 1'b0, 8'd0, 1'b0};
        vecs[4] = '{3, '{{1'b0,1'b0,8'd9}, {1'b0,1'b1,8'd10}, {1'b1,1'b0,8'd11}, 10'd0}, 5, 1'b0, 2, 1'b1, 8'd10, 1'b0};

        #12;
        check("rst_outputs", {busy, imply_flush, trace_pop, trace_push, push_type, push_val,
                              unassign_valid, assign_valid, assign_val, done, unsat}, 0);
        check("rst_vars", {push_var, unassign_var, assign_var, pop_count}, 0);
        reset = 1'b1;

        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++) ld_mem[i] = vecs[v].ent[i];
            load(vecs[v].n);
            execute(vecs[v].done_k, vecs[v].unsat, vecs[v].pcnt, vecs[v].push_en,
                    vecs[v].pvar, vecs[v].pval, 0);
        end

        // start while busy is ignored; sequence identical to vector 0
        for (int i = 0; i < 4; i++) ld_mem[i] = vecs[0].ent[i];
        load(3);
        execute(6, 1'b0, 3, 1'b1, 8'd3, 1'b0, 3);

        // reset during POP: outputs clear without a clock edge
        load(3);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_pop", trace_pop, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_strobes", {busy, imply_flush, trace_pop, trace_push, unassign_valid,
                               assign_valid, done, unsat}, 0);
        check("arst_data", {unassign_var, push_var, assign_var, pop_count}, 0);
        #1 reset = 1'b1;
        check("arst_depth", sp, 2);
        // remaining stack [D x3=1, F x5=0] runs normally
        execute(5, 1'b0, 2, 1'b1, 8'd3, 1'b0, 0);

        // 128 forced entries: unsat, count reaches 128 without wrap
        for (int i = 0; i < 128; i++) ld_mem[i] = {1'b1, i[0], i[7:0]};
        load(128);
        execute(131, 1'b1, 128, 1'b0, 8'd0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
